// File: rtl/si_mac_accumulator_pkg.sv
// rtl/si_mac_accumulator_pkg.sv - shared FSM encodings, signed limits and clog2 for the si_* stages
//
// Purpose: common definitions for the signed-integer pipeline stages
// (MAC accumulator, requantising downscaler, later neuron stages).
// Ports: none (package).

package si_mac_accumulator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } si_state_e;

   localparam logic signed [31:0] SI_MAX_32 = 32'sh7fff_ffff;
   localparam logic signed [31:0] SI_MIN_32 = 32'sh8000_0000;

   // Ceiling log2; si_clog2(1) == 0.
   function automatic int si_clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/si_mac_accumulator_if.sv
// rtl/si_mac_accumulator_if.sv - pair-input and result-output handshake bundle
//
// Purpose: groups the input pair stream and the result stream of the MAC.
// Signals:
//   in_valid/in_ready   input pair handshake
//   act/weight          signed N_ACT operands
//   out_valid/out_ready result handshake towards the downscaler
//   acc_out             signed N_ACC result
// Modports: master = pair source / result sink, slave = the accumulator.

interface si_mac_accumulator_if #(
   parameter int N_ACT = 8,
   parameter int N_ACC = 32
) ();

   logic                    in_valid;
   logic                    in_ready;
   logic signed [N_ACT-1:0] act;
   logic signed [N_ACT-1:0] weight;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [N_ACC-1:0] acc_out;

   modport master (
      output in_valid, act, weight, out_ready,
      input  in_ready, out_valid, acc_out
   );

   modport slave (
      input  in_valid, act, weight, out_ready,
      output in_ready, out_valid, acc_out
   );

endinterface

// File: rtl/si_mac_accumulator_sat_add.sv
// rtl/si_mac_accumulator_sat_add.sv - signed saturating adder
//
// Purpose: N-bit two's-complement add that clamps to the signed range.
// Ports:
//   a, b  in   N  signed addends
//   sum   out  N  clamped sum
//   sat   out  1  high when the true sum fell outside the N-bit range

module si_sat_add #(
   parameter int N = 32
) (
   input  logic signed [N-1:0] a,
   input  logic signed [N-1:0] b,
   output logic signed [N-1:0] sum,
   output logic                sat
);

   logic signed [N:0] wide;

   always_comb begin
      wide = {a[N-1], a} + {b[N-1], b};
      // The top two bits of the N+1 bit sum disagree exactly on overflow;
      // the top bit then carries the true sign of the result.
      sat = wide[N] ^ wide[N-1];
      if (!sat) begin
         sum = wide[N-1:0];
      end else if (wide[N]) begin
         sum = {1'b1, {(N-1){1'b0}}};
      end else begin
         sum = {1'b0, {(N-1){1'b1}}};
      end
   end

endmodule

// File: rtl/si_mac_accumulator.sv
// rtl/si_mac_accumulator.sv - sequential int8 dot product with saturating accumulator
//
// Purpose: accepts N_INPUTS (act, weight) pairs, subtracts the activation
// zero-point, multiplies and accumulates into a saturating N_ACC register
// preloaded with BIAS, then offers the result over a valid/ready handshake.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin a dot product (honoured in IDLE, or in DONE with out_ready)
//   bus    slave modport: in_valid/in_ready/act/weight, out_valid/out_ready/acc_out
//   sat    out  sticky saturation flag for the current/last result
//   busy   out  high while accumulating

module si_mac_accumulator
   import si_mac_accumulator_pkg::*;
#(
   parameter int                      N_ACT    = 8,
   parameter int                      N_ACC    = 32,
   parameter int                      N_INPUTS = 16,
   parameter logic signed [N_ACT-1:0] ACT_ZP   = '0,
   parameter logic signed [N_ACC-1:0] BIAS     = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   si_mac_accumulator_if.slave  bus,
   output logic                 sat,
   output logic                 busy
);

   localparam int PROD_W = 2 * N_ACT + 1;
   localparam int CNT_W  = si_clog2(N_INPUTS) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_INPUTS - 1);

   si_state_e state_q, state_d;
   logic in_ready_q, in_ready_d;
   logic out_valid_q, out_valid_d;
   logic busy_q, busy_d;

   logic signed [N_ACC-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    sat_q, sat_d;

   // Zero-point removal in N_ACT+1 bits cannot overflow.
   logic signed [N_ACT:0]    act_x, zp_x, act_c;
   logic signed [PROD_W-1:0] act_w, wt_w, prod;
   logic signed [N_ACC-1:0]  prod_ext;
   logic signed [N_ACC-1:0]  add_sum;
   logic                     add_sat;
   logic                     beat;

   always_comb begin
      act_x    = {bus.act[N_ACT-1], bus.act};
      zp_x     = {ACT_ZP[N_ACT-1], ACT_ZP};
      act_c    = act_x - zp_x;
      act_w    = {{N_ACT{act_c[N_ACT]}}, act_c};
      wt_w     = {{(N_ACT+1){bus.weight[N_ACT-1]}}, bus.weight};
      prod     = act_w * wt_w;
      prod_ext = {{(N_ACC-PROD_W){prod[PROD_W-1]}}, prod};
   end

   si_sat_add #(.N(N_ACC)) u_sat_add (
      .a   (acc_q),
      .b   (prod_ext),
      .sum (add_sum),
      .sat (add_sat)
   );

   // in_ready_q is high exactly in ACCUM, so a beat can only happen there.
   assign beat = bus.in_valid & in_ready_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ACCUM;
               acc_d   = BIAS;
               cnt_d   = '0;
               sat_d   = 1'b0;
            end
         end
         ST_ACCUM: begin
            if (beat) begin
               acc_d = add_sum;
               sat_d = sat_q | add_sat;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // Result consumed together with start: reload without an IDLE bubble.
            if (bus.out_ready) begin
               if (start) begin
                  state_d = ST_ACCUM;
                  acc_d   = BIAS;
                  cnt_d   = '0;
                  sat_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      in_ready_d  = (state_d == ST_ACCUM);
      busy_d      = (state_d == ST_ACCUM);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   // acc_q only moves in ACCUM or on the DONE->ACCUM reload, so the
   // published result is stable for as long as out_valid is high.
   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.acc_out   = acc_q;
   assign sat           = sat_q;
   assign busy          = busy_q;

endmodule
